// File: rtl/instr_fetch.sv
// Instruction fetch unit: credit-limited in-order fetch into a small instruction FIFO.
// Optional FETCH_PERF_EN adds the perfFetched decoder-transfer counter.
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int unsigned DEPTH    = 4,
  parameter int unsigned MAX_OUT  = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] imemAddr,
  output logic        imemReq,
  input  logic        imemAck,
  input  logic        imemRvalid,
  input  logic [31:0] imemRdata,
  output logic [31:0] instr,
  output logic [31:0] pc,
  output logic        instrValid,
  input  logic        instrReady,
  input  logic        redirect,
  input  logic [31:0] redirectPC,
  input  logic        halt
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perfFetched
`endif
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned SW = CW + 1;
  localparam int unsigned OW = $clog2(MAX_OUT + 1);
  localparam int unsigned QW = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
  localparam int unsigned KW = 8;

  localparam logic [1:0] BOOT = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] HALT = 2'd2;

  logic [1:0]    state;
  logic [1:0]    state_n;
  logic [31:0]   fetch_pc;
  logic [OW-1:0] outstanding;
  logic [KW-1:0] kill_count;

  logic [CW-1:0] fifo_count;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] wr_ptr;
  logic [31:0]   fifo_instr [DEPTH];
  logic [31:0]   fifo_pc    [DEPTH];

  logic [31:0]   pcq [MAX_OUT];
  logic [QW-1:0] q_head;
  logic [QW-1:0] q_tail;

  logic in_run;
  logic do_redirect;
  logic credit_ok;
  logic accept;
  logic resp_live;
  logic push;
  logic pop;
  logic unused_redirect_lsbs;

  function automatic logic [QW-1:0] q_next(input logic [QW-1:0] p);
    return (p == QW'(MAX_OUT - 1)) ? '0 : p + QW'(1);
  endfunction

  assign unused_redirect_lsbs = ^redirectPC[1:0];

  // Request gating: only in RUN, withdrawn by redirect/halt, bounded by outstanding and FIFO credit
  assign in_run      = (state == RUN);
  assign do_redirect = in_run && redirect;
  assign credit_ok   = (SW'(outstanding) < SW'(MAX_OUT)) &&
                       ((SW'(fifo_count) + SW'(outstanding)) < SW'(DEPTH));
  assign imemReq     = in_run && !redirect && !halt && credit_ok;
  assign imemAddr    = fetch_pc;
  assign accept      = imemReq && imemAck;

  // A response is live only when nothing older is still marked for discard
  assign resp_live   = imemRvalid && (kill_count == '0) && !do_redirect;
  assign push        = resp_live;
  assign pop         = instrValid && instrReady && !do_redirect;

  assign instrValid  = (fifo_count != '0);
  assign instr       = fifo_instr[rd_ptr];
  assign pc          = fifo_pc[rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= BOOT;
    else       state <= state_n;
  end

  always_comb begin
    state_n = state;
    case (state)
      BOOT:    state_n = RUN;
      RUN:     if (halt) state_n = HALT;
      HALT:    state_n = HALT;
      default: state_n = BOOT;
    endcase
  end

  // Fetch address, outstanding count and count of responses still to be discarded
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      fetch_pc    <= RESET_PC;
      outstanding <= '0;
      kill_count  <= '0;
    end else if (do_redirect) begin
      fetch_pc    <= {redirectPC[31:2], 2'b00};
      outstanding <= '0;
      kill_count  <= kill_count + KW'(outstanding) - KW'(imemRvalid);
    end else begin
      if (accept) fetch_pc <= fetch_pc + 32'd4;
      if (imemRvalid && (kill_count != '0)) kill_count <= kill_count - KW'(1);
      outstanding <= outstanding + OW'(accept) - OW'(resp_live);
    end
  end

  // In-order queue of PCs for live requests awaiting their response
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      q_head <= '0;
      q_tail <= '0;
      for (int i = 0; i < int'(MAX_OUT); i++) pcq[i] <= '0;
    end else if (do_redirect) begin
      q_head <= '0;
      q_tail <= '0;
    end else begin
      if (accept) begin
        pcq[q_tail] <= fetch_pc;
        q_tail      <= q_next(q_tail);
      end
      if (resp_live) q_head <= q_next(q_head);
    end
  end

  // Instruction FIFO; redirect flushes it ahead of any same-cycle push or pop
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) begin
        fifo_instr[i] <= '0;
        fifo_pc[i]    <= '0;
      end
    end else if (do_redirect) begin
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) begin
        fifo_instr[wr_ptr] <= imemRdata;
        fifo_pc[wr_ptr]    <= pcq[q_head];
        wr_ptr             <= wr_ptr + AW'(1);
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      fifo_count <= fifo_count + CW'(push) - CW'(pop);
    end
  end

`ifdef FETCH_PERF_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                         perfFetched <= '0;
    else if (instrValid && instrReady) perfFetched <= perfFetched + 32'd1;
  end
`endif

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with an in-order memory model returning the address as data.
module tb_instr_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] imemAddr;
  logic        imemReq;
  logic        imemAck;
  logic        imemRvalid;
  logic [31:0] imemRdata;
  logic [31:0] instr;
  logic [31:0] pc;
  logic        instrValid;
  logic        instrReady;
  logic        redirect;
  logic [31:0] redirectPC;
  logic        halt;
`ifdef FETCH_PERF_EN
  logic [31:0] perfFetched;
`endif

  instr_fetch dut (
    .clk        (clk),
    .reset      (reset),
    .imemAddr   (imemAddr),
    .imemReq    (imemReq),
    .imemAck    (imemAck),
    .imemRvalid (imemRvalid),
    .imemRdata  (imemRdata),
    .instr      (instr),
    .pc         (pc),
    .instrValid (instrValid),
    .instrReady (instrReady),
    .redirect   (redirect),
    .redirectPC (redirectPC),
    .halt       (halt)
`ifdef FETCH_PERF_EN
    ,
    .perfFetched(perfFetched)
`endif
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mem_t;
  typedef struct {
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_pc;
  } vec_t;

  mem_t        pend[$];
  logic [31:0] deliv_pc[$];
  logic [31:0] deliv_in[$];
  int          cyc;
  int          lat;
  int          acc_cnt;
  int          checks;
  int          failures;
  logic        s_req;
  logic        s_valid;
  logic [31:0] s_addr;
  logic [31:0] s_pc;
  logic [31:0] s_instr;
  vec_t        vt[14];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic check_deliv(input string name, input int idx, input logic [31:0] exp);
    checks++;
    if (idx >= deliv_pc.size()) begin
      failures++;
      $display("FAIL %s: only %0d instructions delivered, expected pc %h", name, deliv_pc.size(), exp);
    end else if (deliv_pc[idx] !== exp || deliv_in[idx] !== exp) begin
      failures++;
      $display("FAIL %s: got pc %h instr %h expected %h", name, deliv_pc[idx], deliv_in[idx], exp);
    end
  endtask

  // One cycle, entered just after a negedge: drive memory, sample mid-cycle, advance
  task automatic step();
    imemAck = 1'b1;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      imemRvalid = 1'b1;
      imemRdata  = pend[0].addr;
      void'(pend.pop_front());
    end else begin
      imemRvalid = 1'b0;
      imemRdata  = '0;
    end
    #1;
    s_req   = imemReq;
    s_addr  = imemAddr;
    s_valid = instrValid;
    s_pc    = pc;
    s_instr = instr;
    if (imemReq && imemAck) begin
      pend.push_back('{imemAddr, cyc + lat});
      acc_cnt++;
    end
    if (instrValid && instrReady) begin
      deliv_pc.push_back(pc);
      deliv_in.push_back(instr);
    end
    @(negedge clk);
    cyc++;
  endtask

  task automatic clear_model();
    pend.delete();
    deliv_pc.delete();
    deliv_in.delete();
    cyc     = 0;
    acc_cnt = 0;
  endtask

  task automatic do_reset(input int latency);
    reset      = 1'b1;
    redirect   = 1'b0;
    redirectPC = '0;
    halt       = 1'b0;
    instrReady = 1'b1;
    imemAck    = 1'b0;
    imemRvalid = 1'b0;
    imemRdata  = '0;
    lat        = latency;
    clear_model();
    repeat (2) @(negedge clk);
    #1;
    check("rst_req",   32'(imemReq),    32'h0);
    check("rst_valid", 32'(instrValid), 32'h0);
    check("rst_pc",    pc,              32'h0);
    check("rst_instr", instr,           32'h0);
    check("rst_addr",  imemAddr,        32'h0);
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int n;
    int acc_before;
    checks   = 0;
    failures = 0;
    reset    = 1'b1;

    // Startup with 1-cycle memory, then back-pressure until the credit limit closes
    vt[0]  = '{1'b1, 1'b0, 32'd0,  1'b0, 32'd0};
    vt[1]  = '{1'b1, 1'b1, 32'd0,  1'b0, 32'd0};
    vt[2]  = '{1'b1, 1'b1, 32'd4,  1'b0, 32'd0};
    vt[3]  = '{1'b1, 1'b1, 32'd8,  1'b1, 32'd0};
    vt[4]  = '{1'b1, 1'b1, 32'd12, 1'b1, 32'd4};
    vt[5]  = '{1'b1, 1'b1, 32'd16, 1'b1, 32'd8};
    vt[6]  = '{1'b1, 1'b1, 32'd20, 1'b1, 32'd12};
    vt[7]  = '{1'b1, 1'b1, 32'd24, 1'b1, 32'd16};
    vt[8]  = '{1'b0, 1'b1, 32'd28, 1'b1, 32'd20};
    vt[9]  = '{1'b0, 1'b1, 32'd32, 1'b1, 32'd20};
    vt[10] = '{1'b0, 1'b0, 32'd36, 1'b1, 32'd20};
    vt[11] = '{1'b0, 1'b0, 32'd36, 1'b1, 32'd20};
    vt[12] = '{1'b1, 1'b0, 32'd36, 1'b1, 32'd20};
    vt[13] = '{1'b1, 1'b1, 32'd36, 1'b1, 32'd24};

    do_reset(1);
    for (int k = 0; k < 14; k++) begin
      instrReady = vt[k].ready;
      step();
      check($sformatf("t%0d_req", k),   32'(s_req),   32'(vt[k].exp_req));
      check($sformatf("t%0d_addr", k),  s_addr,       vt[k].exp_addr);
      check($sformatf("t%0d_valid", k), 32'(s_valid), 32'(vt[k].exp_valid));
      if (vt[k].exp_valid) begin
        check($sformatf("t%0d_pc", k),    s_pc,    vt[k].exp_pc);
        check($sformatf("t%0d_instr", k), s_instr, vt[k].exp_pc);
      end
    end

    // Decoder stalled for 20 cycles: exactly DEPTH requests, head held
    do_reset(1);
    instrReady = 1'b0;
    repeat (20) step();
    check("stall_accepts", 32'(acc_cnt), 32'd4);
    check("stall_req",     32'(s_req),   32'h0);
    check("stall_valid",   32'(s_valid), 32'h1);
    check("stall_pc",      s_pc,         32'h0);

    // Redirect with two requests in flight on a 3-cycle memory
    do_reset(3);
    repeat (3) step();
    check("redir_outstanding", 32'(acc_cnt), 32'd2);
    redirect   = 1'b1;
    redirectPC = 32'h100;
    step();
    redirect = 1'b0;
    deliv_pc.delete();
    deliv_in.delete();
    step();
    check("redir_req",  32'(s_req), 32'h1);
    check("redir_addr", s_addr,     32'h100);
    n = 0;
    while (deliv_pc.size() < 2 && n < 30) begin step(); n++; end
    check_deliv("redir_first", 0, 32'h100);
    check_deliv("redir_second", 1, 32'h104);

    // Redirect near the top of the address space, low bits ignored, wraps to 0
    do_reset(1);
    repeat (5) step();
    redirect   = 1'b1;
    redirectPC = 32'hFFFF_FFFA;
    step();
    redirect = 1'b0;
    deliv_pc.delete();
    deliv_in.delete();
    n = 0;
    while (deliv_pc.size() < 3 && n < 30) begin step(); n++; end
    check_deliv("wrap_0", 0, 32'hFFFF_FFF8);
    check_deliv("wrap_1", 1, 32'hFFFF_FFFC);
    check_deliv("wrap_2", 2, 32'h0000_0000);

    // Halt with one request in flight; a later redirect is ignored
    do_reset(3);
    repeat (2) step();
    halt = 1'b1;
    step();
    halt = 1'b0;
    check("halt_req_withdrawn", 32'(s_req), 32'h0);
    repeat (8) step();
    redirect   = 1'b1;
    redirectPC = 32'h200;
    step();
    redirect = 1'b0;
    repeat (5) step();
    check("halt_accepts", 32'(acc_cnt),         32'd1);
    check("halt_ndeliv",  32'(deliv_pc.size()), 32'd1);
    check_deliv("halt_deliv", 0, 32'h0);
    check("halt_addr",  s_addr,       32'h4);
    check("halt_req",   32'(s_req),   32'h0);
    check("halt_valid", 32'(s_valid), 32'h0);

    // Halt and redirect together: flush and kill, then no further fetching
    do_reset(1);
    repeat (4) step();
    acc_before = acc_cnt;
    halt       = 1'b1;
    redirect   = 1'b1;
    redirectPC = 32'h40;
    step();
    halt     = 1'b0;
    redirect = 1'b0;
    deliv_pc.delete();
    deliv_in.delete();
    repeat (6) step();
    check("hr_addr",    s_addr,                  32'h40);
    check("hr_accepts", 32'(acc_cnt),            32'(acc_before));
    check("hr_ndeliv",  32'(deliv_pc.size()),    32'h0);
    check("hr_valid",   32'(s_valid),            32'h0);

    // Asynchronous reset in the middle of a burst
    do_reset(1);
    repeat (7) step();
    #2;
    check("mid_pre_pc", pc, 32'd16);
`ifdef FETCH_PERF_EN
    check("mid_pre_perf", perfFetched, 32'(deliv_pc.size()));
`endif
    reset = 1'b1;
    #1;
    check("mid_req",   32'(imemReq),    32'h0);
    check("mid_valid", 32'(instrValid), 32'h0);
    check("mid_pc",    pc,              32'h0);
    check("mid_instr", instr,           32'h0);
    check("mid_addr",  imemAddr,        32'h0);
`ifdef FETCH_PERF_EN
    check("mid_perf", perfFetched, 32'h0);
`endif
    clear_model();
    imemRvalid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    step();
    check("restart_k0_req", 32'(s_req), 32'h0);
    step();
    check("restart_k1_req",  32'(s_req), 32'h1);
    check("restart_k1_addr", s_addr,     32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
